// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with registered outputs
// Optional 8-bit frame counter output: define VGA_TG_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter logic        HS_POL = 1'b0,
  parameter logic        VS_POL = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          pixel_clk_25,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          vid_active,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TG_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int unsigned H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_VIS + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_VIS + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;
  localparam int unsigned MAX_TOTAL = 1 << CW;
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_cfg
    $error("vga_timing_gen: zero porch/sync width or total exceeds counter range");
  end

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW-1:0] r_x_pos;
  logic [CW-1:0] r_y_pos;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_vid_active;
  logic          r_line_start;
  logic          r_frame_start;

  logic [31:0]   w_h_ext;
  logic [31:0]   w_v_ext;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_h_zero;
  logic          w_v_zero;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_vid;

  // Compare in 32 bits so visible/sync bounds up to 2^CW stay exact.
  assign w_h_ext  = 32'(r_h_cnt);
  assign w_v_ext  = 32'(r_v_cnt);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_h_zero = (r_h_cnt == '0);
  assign w_v_zero = (r_v_cnt == '0);
  assign w_hs_act = (w_h_ext >= HS_START) && (w_h_ext < HS_END);
  assign w_vs_act = (w_v_ext >= VS_START) && (w_v_ext < VS_END);
  assign w_vid    = (w_h_ext < H_VIS) && (w_v_ext < V_VIS);

  always_ff @(posedge pixel_clk_25 or posedge reset) begin
    if (reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_x_pos       <= '0;
      r_y_pos       <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_vid_active  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (en) begin
        r_h_cnt <= w_h_last ? '0 : r_h_cnt + CW'(1);
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
        end
        // Outputs describe the pixel the counters point at before this edge.
        r_x_pos       <= r_h_cnt;
        r_y_pos       <= r_v_cnt;
        r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
        r_vid_active  <= w_vid;
        r_line_start  <= w_h_zero;
        r_frame_start <= w_h_zero && w_v_zero;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vid_active  = r_vid_active;
  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TG_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge pixel_clk_25 or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= 8'd0;
    end else if (en && w_h_zero && w_v_zero) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and small raster)
// Frame counter checks are built when VGA_TG_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

  typedef struct packed {
    int unsigned hv, hf, hsw, hb, vv, vf, vsw, vb;
    logic        hp, vp;
  } tim_t;

  localparam tim_t TD = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam tim_t TS = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

  logic       clk;
  logic       reset;
  logic       en;
  logic       d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_TG_FRAME_CNT_EN
  logic [7:0] d_fcnt, s_fcnt;
`endif
  logic [24:0] act_d, act_s;

  int          tests, fails, cyc;
  int unsigned n_en;
  bit          fired;

  assign act_d = {d_hs, d_vs, d_vid, d_ls, d_fs, d_x, d_y};
  assign act_s = {s_hs, s_vs, s_vid, s_ls, s_fs, s_x, s_y};

  vga_timing_gen u_dut_def (
    .pixel_clk_25(clk),
    .reset       (reset),
    .en          (en),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .vid_active  (d_vid),
    .x_pos       (d_x),
    .y_pos       (d_y),
    .line_start  (d_ls),
`ifdef VGA_TG_FRAME_CNT_EN
    .frame_cnt   (d_fcnt),
`endif
    .frame_start (d_fs)
  );

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
  ) u_dut_small (
    .pixel_clk_25(clk),
    .reset       (reset),
    .en          (en),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .vid_active  (s_vid),
    .x_pos       (s_x),
    .y_pos       (s_y),
    .line_start  (s_ls),
`ifdef VGA_TG_FRAME_CNT_EN
    .frame_cnt   (s_fcnt),
`endif
    .frame_start (s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n enabled edges since reset; f = last edge was enabled.
  function automatic logic [24:0] ref_out(input tim_t t, input int unsigned n, input bit f);
    int unsigned ht, vt, p, x, y;
    logic hs, vs, vid;
    ht = t.hv + t.hf + t.hsw + t.hb;
    vt = t.vv + t.vf + t.vsw + t.vb;
    if (n == 0) return {~t.hp, ~t.vp, 3'b000, 20'd0};
    p   = n - 1;
    x   = p % ht;
    y   = (p / ht) % vt;
    hs  = (x >= t.hv + t.hf && x < t.hv + t.hf + t.hsw) ? t.hp : ~t.hp;
    vs  = (y >= t.vv + t.vf && y < t.vv + t.vf + t.vsw) ? t.vp : ~t.vp;
    vid = (x < t.hv) && (y < t.vv);
    return {hs, vs, vid, f && x == 0, f && x == 0 && y == 0, x[9:0], y[9:0]};
  endfunction

  function automatic logic [7:0] ref_fcnt(input tim_t t, input int unsigned n);
    int unsigned fp;
    fp = (t.hv + t.hf + t.hsw + t.hb) * (t.vv + t.vf + t.vsw + t.vb);
    if (n == 0) return 8'd0;
    return 8'(((n - 1) / fp + 1) % 256);
  endfunction

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    cyc++;
    if (reset) begin
      n_en  = 0;
      fired = 1'b0;
    end else begin
      if (e) n_en++;
      fired = e;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] ed, es;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (d_hs !== 1'b1 || s_hs !== 1'b0 || d_vs !== 1'b1 || s_vs !== 1'b0) begin
      fails++;
      $display("FAIL reset_sync_levels got d=%b%b s=%b%b want d=11 s=00", d_hs, d_vs, s_hs, s_vs);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      ed = ref_out(TD, n_en, fired);
      es = ref_out(TS, n_en, fired);
      tests++;
      if ({act_d, act_s} !== {ed, es}) begin
        fails++;
        $display("FAIL reset_hold got d=%h s=%h want d=%h s=%h", act_d, act_s, ed, es);
      end
    end
  endtask

  task automatic test_first_edge();
    logic [24:0] ed, es;
    reset = 1'b0;
    tick(1'b1);
    ed = ref_out(TD, n_en, fired);
    es = ref_out(TS, n_en, fired);
    tests++;
    if ({act_d, act_s} !== {ed, es}) begin
      fails++;
      $display("FAIL first_edge_model got d=%h s=%h want d=%h s=%h", act_d, act_s, ed, es);
    end
    tests++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_vid !== 1'b1 || d_ls !== 1'b1 || d_fs !== 1'b1) begin
      fails++;
      $display("FAIL first_edge got x=%0d y=%0d vid=%b ls=%b fs=%b want 0 0 1 1 1",
               d_x, d_y, d_vid, d_ls, d_fs);
    end
  endtask

  task automatic test_default_lines();
    int hs_low = 0;
    int last_ls = -1;
    int bad_per = 0;
    int ls_cnt = 0;
    logic [24:0] ed, es;
    for (int i = 0; i < 2399; i++) begin
      tick(1'b1);
      ed = ref_out(TD, n_en, fired);
      es = ref_out(TS, n_en, fired);
      tests++;
      if ({act_d, act_s} !== {ed, es}) begin
        fails++;
        $display("FAIL default_lines n=%0d got d=%h s=%h want d=%h s=%h", n_en, act_d, act_s, ed, es);
      end
      if ((n_en - 1) / 800 == 1 && d_hs === 1'b0) hs_low++;
      if (d_ls === 1'b1) begin
        if (last_ls >= 0 && cyc - last_ls != 800) bad_per++;
        last_ls = cyc;
        ls_cnt++;
      end
    end
    tests++;
    if (hs_low != 96) begin
      fails++;
      $display("FAIL hsync_low_width got %0d want 96", hs_low);
    end
    tests++;
    if (bad_per != 0 || ls_cnt != 2) begin
      fails++;
      $display("FAIL line_start_period got bad=%0d count=%0d want bad=0 count=2", bad_per, ls_cnt);
    end
  endtask

  task automatic test_small_frames();
    int seen = 0;
    int last = -1;
    int vs_hi = 0;
    int vid_hi = 0;
    int bad = 0;
    logic [24:0] ed, es;
    for (int i = 0; i < 150; i++) begin
      tick(1'b1);
      ed = ref_out(TD, n_en, fired);
      es = ref_out(TS, n_en, fired);
      tests++;
      if ({act_d, act_s} !== {ed, es}) begin
        fails++;
        $display("FAIL small_frames n=%0d got d=%h s=%h want d=%h s=%h", n_en, act_d, act_s, ed, es);
      end
      if (s_fs === 1'b1) begin
        if (seen > 0 && (cyc - last != 48 || vs_hi != 8 || vid_hi != 12)) bad++;
        seen++;
        last   = cyc;
        vs_hi  = 0;
        vid_hi = 0;
      end
      if (s_vs === 1'b1) vs_hi++;
      if (s_vid === 1'b1) vid_hi++;
    end
    tests++;
    if (bad != 0 || seen < 3) begin
      fails++;
      $display("FAIL small_frame_shape got bad=%0d frames=%0d want bad=0 frames>=3", bad, seen);
    end
  endtask

  task automatic test_en_alternate();
    int last_ls = -1;
    int bad = 0;
    int ls_cnt = 0;
    logic prev_ls = 1'b0;
    logic [24:0] ed, es;
    for (int i = 0; i < 3300; i++) begin
      tick((i % 2) == 0);
      ed = ref_out(TD, n_en, fired);
      es = ref_out(TS, n_en, fired);
      tests++;
      if ({act_d, act_s} !== {ed, es}) begin
        fails++;
        $display("FAIL en_alternate n=%0d got d=%h s=%h want d=%h s=%h", n_en, act_d, act_s, ed, es);
      end
      if (d_ls === 1'b1) begin
        if (prev_ls === 1'b1) bad++;
        if (last_ls >= 0 && cyc - last_ls != 1600) bad++;
        last_ls = cyc;
        ls_cnt++;
      end
      prev_ls = d_ls;
    end
    tests++;
    if (bad != 0 || ls_cnt < 2) begin
      fails++;
      $display("FAIL en_alternate_period got bad=%0d count=%0d want bad=0 count>=2", bad, ls_cnt);
    end
  endtask

  task automatic test_random_en();
    logic [24:0] ed, es;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0);
      ed = ref_out(TD, n_en, fired);
      es = ref_out(TS, n_en, fired);
      tests++;
      if ({act_d, act_s} !== {ed, es}) begin
        fails++;
        $display("FAIL random_en n=%0d got d=%h s=%h want d=%h s=%h", n_en, act_d, act_s, ed, es);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit found = 1'b0;
    logic [24:0] ed, es;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1'b1);
      if (d_x === 10'd300) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL midframe_reach got x=%0d want 300 within 1000 cycles", d_x);
    end
    #2 reset = 1'b1;
    #1;
    n_en  = 0;
    fired = 1'b0;
    ed = ref_out(TD, n_en, fired);
    es = ref_out(TS, n_en, fired);
    tests++;
    if ({act_d, act_s} !== {ed, es}) begin
      fails++;
      $display("FAIL async_reset got d=%h s=%h want d=%h s=%h", act_d, act_s, ed, es);
    end
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
    tick(1'b0);
    ed = ref_out(TD, n_en, fired);
    es = ref_out(TS, n_en, fired);
    tests++;
    if ({act_d, act_s} !== {ed, es}) begin
      fails++;
      $display("FAIL post_reset_idle got d=%h s=%h want d=%h s=%h", act_d, act_s, ed, es);
    end
    tick(1'b1);
    tests++;
    if (d_x !== 10'd0 || d_y !== 10'd0 || d_fs !== 1'b1 || s_fs !== 1'b1) begin
      fails++;
      $display("FAIL restart got x=%0d y=%0d fs=%b sfs=%b want 0 0 1 1", d_x, d_y, d_fs, s_fs);
    end
  endtask

`ifdef VGA_TG_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [7:0] efd, efs;
    for (int i = 0; i < 13000 && n_en < 12289; i++) begin
      tick(1'b1);
      efd = ref_fcnt(TD, n_en);
      efs = ref_fcnt(TS, n_en);
      tests++;
      if (d_fcnt !== efd || s_fcnt !== efs) begin
        fails++;
        $display("FAIL frame_cnt n=%0d got d=%0d s=%0d want d=%0d s=%0d", n_en, d_fcnt, s_fcnt, efd, efs);
      end
    end
    tests++;
    if (n_en != 12289 || s_fcnt !== 8'd1 || s_fs !== 1'b1) begin
      fails++;
      $display("FAIL frame_cnt_257 got n=%0d cnt=%0d fs=%b want n=12289 cnt=1 fs=1", n_en, s_fcnt, s_fs);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    tests = 0;
    fails = 0;
    cyc   = 0;
    n_en  = 0;
    fired = 1'b0;
    test_reset();
    test_first_edge();
    test_default_lines();
    test_small_frames();
    test_en_alternate();
    test_random_en();
    test_reset_midframe();
`ifdef VGA_TG_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator that replaces the fixed 640x480 controller. Horizontal and vertical timing and sync polarities are set at elaboration. It adds a pixel clock enable, registered glitch-free outputs, and line and frame start strobes. It sits between the pixel clock domain and the paint-tool pixel pipeline and drives the Basys-3 VGA connector sync pins directly.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 10, coordinate/counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- pixel_clk_25 in 1 pixel clock
- reset in 1 asynchronous, active-high reset
- en in 1 pixel enable; counters and outputs advance only on edges where en=1
- hsync out 1 horizontal sync, registered
- vsync out 1 vertical sync, registered
- vid_active out 1 current pixel is in the visible area, registered
- x_pos out CW horizontal count of the current pixel, range 0..H_TOTAL-1
- y_pos out CW vertical count of the current pixel, range 0..V_TOTAL-1
- line_start out 1 one-cycle pulse aligned with x_pos=0
- frame_start out 1 one-cycle pulse aligned with x_pos=0, y_pos=0

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters h_cnt and v_cnt are CW bits wide.
- On each en=1 edge:
  - h_cnt increments; it wraps to 0 after H_TOTAL-1.
  - v_cnt increments on the h wrap; it wraps to 0 after V_TOTAL-1.
- On the same en=1 edge, all outputs are loaded from the pre-increment counter values:
  - x_pos = h_cnt; y_pos = v_cnt.
  - vid_active = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - hsync = HS_POL when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC, otherwise ~HS_POL.
  - vsync = VS_POL when V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC, otherwise ~VS_POL. vsync changes only together with an x_pos=0 pixel.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
- On en=0 edges:
  - counters, x_pos, y_pos, hsync, vsync and vid_active hold.
  - line_start and frame_start are forced to 0, so each strobe lasts exactly one clock.
- Sync and active outputs are all flops. No combinational path from counters to pins.
- Elaboration fails ($error) if any porch or sync parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2^CW.

## Timing
- Reset (asynchronous, takes effect immediately):
  - h_cnt=0, v_cnt=0, x_pos=0, y_pos=0.
  - hsync=~HS_POL, vsync=~VS_POL (both inactive).
  - vid_active=0, line_start=0, frame_start=0.
- Latency: outputs reflect the counter state one enabled edge earlier.
  - The first en=1 edge after reset release gives x_pos=0, y_pos=0, vid_active=1, line_start=1, frame_start=1.
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL*V_TOTAL enabled cycles.
- Wrap: after x_pos=H_TOTAL-1, y_pos=V_TOTAL-1, the next enabled edge gives x_pos=0, y_pos=0 and frame_start=1.
- Reset mid-frame returns all outputs to reset values at once. The raster restarts at (0,0) on the first enabled edge after release.
- en toggling every cycle (50 MHz clock, 25 MHz pixel rate) is legal. Strobes then last one clock, not one pixel.

## Configuration
- VGA_TG_FRAME_CNT_EN defined:
  - adds output frame_cnt, 8 bits.
  - reset value 0.
  - increments on the same edge that drives frame_start=1, and wraps 255→0.
  - the first frame after reset reads 1.
- Not defined: the port is absent and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Defaults, en=1, release reset → first edge x=0, y=0, vid_active=1, frame_start=1; hsync low for exactly 96 cycles at x=656..751; line_start every 800 cycles.
- Defaults, full frame → vsync low during lines 490..491 only; vid_active high for 640×480 = 307200 cycles; frame_start period 420000 cycles.
- H_VIS=4, H_FP=1, H_SYNC=2, H_BP=1, V_VIS=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, VS_POL=1 → hsync high at x=5..6; vsync high at y=4; frame period 48 cycles; x wraps 7→0.
- en alternating 1/0 → coordinates hold on en=0 edges, line period is 1600 clocks, and strobes are 1 clock wide.
- Reset pulse at x=300, y=200 → outputs go to reset values immediately; after release, the first enabled edge gives x=0, y=0, frame_start=1.
- VGA_TG_FRAME_CNT_EN defined, run 257 frames → frame_cnt reads 1, 2, …, 255, 0, 1, and steps on each frame_start edge.
